// File: rtl/scroll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scroll_pkg
// Description : Shared state encoding and default sizing for the scrolling
//               ID display sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package scroll_pkg;

    localparam int DIGITS_DEF     = 13;
    localparam int HOLD_TICKS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Up/down modulo-DIGITS window position counter. o_wrap flags
//               a step that lands on position 0 (end of a lap).
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter
    import scroll_pkg::*;
#(
    parameter int DIGITS   = DIGITS_DEF,
    parameter int POS_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_step,
    input  logic                i_down,
    output logic [POS_BITS-1:0] o_pos,
    output logic                o_wrap
);

    localparam logic [POS_BITS-1:0] c_last = POS_BITS'(DIGITS - 1);
    localparam logic [POS_BITS-1:0] c_one  = POS_BITS'(1);

    logic [POS_BITS-1:0] r_pos;
    logic [POS_BITS-1:0] w_next;

    // Next position with modulo wrap in either direction
    always_comb begin
        w_next = r_pos;
        if (i_down) begin
            w_next = (r_pos == '0) ? c_last : (r_pos - c_one);
        end else begin
            w_next = (r_pos == c_last) ? '0 : (r_pos + c_one);
        end
    end

    assign o_wrap = i_step && (w_next == '0);
    assign o_pos  = r_pos;

    // Position register: clear has priority over a step
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pos <= '0;
        end else if (i_clr) begin
            r_pos <= '0;
        end else if (i_step) begin
            r_pos <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scroll_ctrl
// Description : Sequencing controller for the scrolling ID display. Drives
//               shifter load/step/direction, tracks the window offset and
//               handles start, pause, single-lap/continuous and lap hold.
//               Optional macro SCROLL_CTRL_BLINK_EN: blink `blank` in PAUSE.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int DIGITS     = DIGITS_DEF,
    parameter int POS_BITS   = 4,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic                pause,
    input  logic                dir,
    input  logic                mode_once,
    output logic                sh_ld,
    output logic                sh_en,
    output logic                sh_dir,
    output logic [POS_BITS-1:0] pos,
    output logic                busy,
    output logic                lap_done,
    output logic                blank
);

    localparam int              c_hw        = $clog2(HOLD_TICKS + 1);
    localparam logic [c_hw-1:0] c_hold_last = c_hw'(HOLD_TICKS - 1);
    localparam logic [c_hw-1:0] c_hold_one  = c_hw'(1);

    state_t          r_state;
    state_t          w_next;
    logic [c_hw-1:0] r_hold;
    logic            r_ret_hold;
    logic            r_once;
    logic            r_sh_ld;
    logic            r_sh_en;
    logic            r_sh_dir;
    logic            r_busy;
    logic            r_lap;

    logic w_run_tick;
    logic w_hold_tick;
    logic w_hold_end;
    logic w_pause_go;
    logic w_wrap;

    // Event qualification: start beats pause, pause beats tick
    assign w_run_tick  = (r_state == ST_RUN)  && tick && !start && !pause;
    assign w_hold_tick = (r_state == ST_HOLD) && tick && !start && !pause;
    assign w_hold_end  = w_hold_tick && (r_hold == c_hold_last);
    assign w_pause_go  = !start && pause &&
                         ((r_state == ST_RUN) || (r_state == ST_HOLD));

    wrap_counter #(
        .DIGITS   (DIGITS),
        .POS_BITS (POS_BITS)
    ) u_pos (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (start),
        .i_step (w_run_tick),
        .i_down (r_sh_dir),
        .o_pos  (pos),
        .o_wrap (w_wrap)
    );

    // Next-state decode
    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_IDLE;
                ST_LOAD:  w_next = ST_RUN;
                ST_RUN: begin
                    if (pause)       w_next = ST_PAUSE;
                    else if (w_wrap) w_next = ST_HOLD;
                end
                ST_HOLD: begin
                    if (pause)           w_next = ST_PAUSE;
                    else if (w_hold_end) w_next = r_once ? ST_IDLE : ST_RUN;
                end
                ST_PAUSE: begin
                    if (pause) w_next = r_ret_hold ? ST_HOLD : ST_RUN;
                end
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Hold counter, pause origin and latched lap mode
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold     <= '0;
            r_ret_hold <= 1'b0;
            r_once     <= 1'b0;
        end else begin
            if (start || w_run_tick || w_hold_end) begin
                r_hold <= '0;
            end else if (w_hold_tick) begin
                r_hold <= r_hold + c_hold_one;
            end
            if (w_pause_go) begin
                r_ret_hold <= (r_state == ST_HOLD);
            end
            if (r_state == ST_LOAD) begin
                r_once <= mode_once;
            end
        end
    end

    // Registered shifter controls and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sh_ld  <= 1'b0;
            r_sh_en  <= 1'b0;
            r_sh_dir <= 1'b0;
            r_busy   <= 1'b0;
            r_lap    <= 1'b0;
        end else begin
            r_sh_ld <= (w_next == ST_LOAD);
            r_sh_en <= w_run_tick;
            r_lap   <= w_run_tick && w_wrap;
            r_busy  <= (w_next != ST_IDLE);
            if (w_next == ST_IDLE) begin
                r_sh_dir <= 1'b0;
            end else if (r_state == ST_LOAD) begin
                r_sh_dir <= dir;
            end
        end
    end

    assign sh_ld    = r_sh_ld;
    assign sh_en    = r_sh_en;
    assign sh_dir   = r_sh_dir;
    assign busy     = r_busy;
    assign lap_done = r_lap;

`ifdef SCROLL_CTRL_BLINK_EN
    logic r_blank;

    // Blink while paused: toggle per tick, cleared on any exit from PAUSE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_blank <= 1'b0;
        end else if (w_next != ST_PAUSE) begin
            r_blank <= 1'b0;
        end else if ((r_state == ST_PAUSE) && tick && !pause) begin
            r_blank <= ~r_blank;
        end
    end

    assign blank = r_blank;
`else
    assign blank = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_ctrl
// Description : Self-checking bench for scroll_ctrl: directed scenarios plus
//               random stimulus against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_ctrl;

    localparam int D = 13;
    localparam int H = 4;
`ifdef SCROLL_CTRL_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_RUN   = 2;
    localparam int P_HOLD  = 3;
    localparam int P_PAUSE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       dir = 1'b0;
    logic       mode_once = 1'b0;
    logic       sh_ld, sh_en, sh_dir, busy, lap_done, blank;
    logic [3:0] pos;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_ph   = P_IDLE;
    int m_pos  = 0;
    int m_hold = 0;
    int m_ret  = P_RUN;
    bit m_dir  = 1'b0;
    bit m_once = 1'b0;
    bit m_blink = 1'b0;
    bit e_ld = 1'b0, e_en = 1'b0, e_lap = 1'b0;

    always #5 clk = ~clk;

    scroll_ctrl #(.DIGITS(D), .POS_BITS(4), .HOLD_TICKS(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .pause     (pause),
        .dir       (dir),
        .mode_once (mode_once),
        .sh_ld     (sh_ld),
        .sh_en     (sh_en),
        .sh_dir    (sh_dir),
        .pos       (pos),
        .busy      (busy),
        .lap_done  (lap_done),
        .blank     (blank)
    );

    // Behavioural model: one update per rising edge, from the sampled inputs
    task automatic model_edge(input bit r, input bit s, input bit p, input bit t,
                              input bit d, input bit mo);
        e_ld = 1'b0; e_en = 1'b0; e_lap = 1'b0;
        if (!r) begin
            m_ph = P_IDLE; m_pos = 0; m_hold = 0; m_dir = 1'b0; m_blink = 1'b0;
        end else if (s) begin
            m_ph = P_LOAD; m_pos = 0; m_hold = 0; m_blink = 1'b0; e_ld = 1'b1;
        end else begin
            case (m_ph)
                P_LOAD: begin
                    m_dir = d; m_once = mo; m_ph = P_RUN;
                end
                P_RUN: begin
                    if (p) begin
                        m_ret = P_RUN; m_ph = P_PAUSE; m_blink = 1'b0;
                    end else if (t) begin
                        m_pos = m_dir ? (m_pos + D - 1) % D : (m_pos + 1) % D;
                        e_en = 1'b1;
                        if (m_pos == 0) begin
                            e_lap = 1'b1; m_ph = P_HOLD; m_hold = 0;
                        end
                    end
                end
                P_HOLD: begin
                    if (p) begin
                        m_ret = P_HOLD; m_ph = P_PAUSE; m_blink = 1'b0;
                    end else if (t) begin
                        m_hold++;
                        if (m_hold == H) begin
                            m_hold = 0;
                            m_ph = m_once ? P_IDLE : P_RUN;
                        end
                    end
                end
                P_PAUSE: begin
                    if (p) m_ph = m_ret;
                    else if (t) m_blink = !m_blink;
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of control inputs, advance the model, settle past the edge
    task automatic cyc(input bit r, input bit s, input bit p, input bit t);
        reset = r; start = s; pause = p; tick = t;
        @(posedge clk);
        model_edge(r, s, p, t, dir, mode_once);
        #1;
        reset = 1'b1; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        n_cmp++;
        if ({sh_ld, sh_en, sh_dir, busy, lap_done, blank, pos} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_idle: outputs=%b want=0", {sh_ld, sh_en, sh_dir, busy, lap_done, blank, pos});
        end
        dir = 1'b0; mode_once = 1'b1;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 1);
        n_cmp++;
        if ({busy, pos} !== {1'b1, 4'd5}) begin
            n_bad++;
            $display("FAIL mid_run: busy,pos=%b,%0d want 1,5", busy, pos);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1);
            n_cmp++;
            if ({sh_ld, sh_en, sh_dir, busy, lap_done, blank, pos} !== 10'd0) begin
                n_bad++;
                $display("FAIL reset_mid_run[%0d]: outputs=%b want=0", k,
                         {sh_ld, sh_en, sh_dir, busy, lap_done, blank, pos});
            end
        end
        cyc(1, 0, 1, 1);
        n_cmp++;
        if ({sh_ld, sh_en, busy, pos} !== 7'd0) begin
            n_bad++;
            $display("FAIL idle_ignores: outputs=%b want=0", {sh_ld, sh_en, busy, pos});
        end
    endtask

    task automatic test_single_lap();
        int n_ld = 0;
        int n_en = 0;
        dir = 1'b0; mode_once = 1'b1;
        cyc(1, 1, 0, 0);
        n_ld += int'(sh_ld);
        n_cmp++;
        if ({sh_ld, busy, pos} !== {1'b1, 1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL lap_load: ld,busy,pos=%b,%b,%0d want 1,1,0", sh_ld, busy, pos);
        end
        cyc(1, 0, 0, 0);
        n_ld += int'(sh_ld);
        for (int i = 1; i <= 17; i++) begin
            cyc(1, 0, 0, 1);
            n_en += int'(sh_en); n_ld += int'(sh_ld);
            if (i <= 13) begin
                n_cmp++;
                if ({sh_en, lap_done, pos} !== {1'b1, (i == 13), 4'(i % 13)}) begin
                    n_bad++;
                    $display("FAIL lap_step[%0d]: en,lap,pos=%b,%b,%0d want 1,%0d,%0d",
                             i, sh_en, lap_done, pos, (i == 13), i % 13);
                end
            end else begin
                n_cmp++;
                if ({sh_en, lap_done, busy} !== {1'b0, 1'b0, (i != 17)}) begin
                    n_bad++;
                    $display("FAIL lap_hold[%0d]: en,lap,busy=%b,%b,%b want 0,0,%0d",
                             i, sh_en, lap_done, busy, (i != 17));
                end
            end
            cyc(1, 0, 0, 0);
            n_en += int'(sh_en); n_ld += int'(sh_ld);
        end
        n_cmp++;
        if (n_ld != 1 || n_en != 13) begin
            n_bad++;
            $display("FAIL lap_counts: ld=%0d en=%0d want 1,13", n_ld, n_en);
        end
    endtask

    task automatic test_right_scroll();
        dir = 1'b1; mode_once = 1'b1;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        n_cmp++;
        if ({sh_en, sh_dir, pos} !== {1'b1, 1'b1, 4'd12}) begin
            n_bad++;
            $display("FAIL right_first: en,dir,pos=%b,%b,%0d want 1,1,12", sh_en, sh_dir, pos);
        end
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 0, 0, 1);
            n_cmp++;
            if ({lap_done, pos} !== {(i == 12), 4'(12 - i)}) begin
                n_bad++;
                $display("FAIL right_step[%0d]: lap,pos=%b,%0d want %0d,%0d",
                         i, lap_done, pos, (i == 12), 12 - i);
            end
        end
        repeat (H) cyc(1, 0, 0, 1);
        n_cmp++;
        if ({busy, sh_dir} !== 2'b00) begin
            n_bad++;
            $display("FAIL right_idle: busy,dir=%b,%b want 0,0", busy, sh_dir);
        end
        dir = 1'b0;
    endtask

    task automatic test_pause();
        bit want_blank;
        dir = 1'b0; mode_once = 1'b0;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (3) begin
            cyc(1, 0, 0, 1);
            cyc(1, 0, 0, 0);
        end
        cyc(1, 0, 1, 0);
        n_cmp++;
        if ({sh_en, busy, pos} !== {1'b0, 1'b1, 4'd3}) begin
            n_bad++;
            $display("FAIL pause_enter: en,busy,pos=%b,%b,%0d want 0,1,3", sh_en, busy, pos);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 0, 1);
            want_blank = BLINK && (k % 2 == 0);
            n_cmp++;
            if ({sh_en, blank, pos} !== {1'b0, want_blank, 4'd3}) begin
                n_bad++;
                $display("FAIL pause_tick[%0d]: en,blank,pos=%b,%b,%0d want 0,%b,3",
                         k, sh_en, blank, pos, want_blank);
            end
        end
        cyc(1, 0, 1, 0);
        n_cmp++;
        if ({sh_en, blank, pos} !== {1'b0, 1'b0, 4'd3}) begin
            n_bad++;
            $display("FAIL pause_exit: en,blank,pos=%b,%b,%0d want 0,0,3", sh_en, blank, pos);
        end
        cyc(1, 0, 0, 1);
        n_cmp++;
        if ({sh_en, pos} !== {1'b1, 4'd4}) begin
            n_bad++;
            $display("FAIL pause_resume: en,pos=%b,%0d want 1,4", sh_en, pos);
        end
    endtask

    task automatic test_restart_collision();
        repeat (3) cyc(1, 0, 0, 1);
        n_cmp++;
        if (pos !== 4'd7) begin
            n_bad++;
            $display("FAIL restart_pre: pos=%0d want 7", pos);
        end
        cyc(1, 1, 0, 0);
        n_cmp++;
        if ({sh_ld, pos} !== {1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL restart_load: ld,pos=%b,%0d want 1,0", sh_ld, pos);
        end
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 1);
        n_cmp++;
        if ({sh_en, busy, pos} !== {1'b0, 1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL tick_pause: en,busy,pos=%b,%b,%0d want 0,1,0", sh_en, busy, pos);
        end
        cyc(1, 0, 0, 1);
        n_cmp++;
        if ({sh_en, blank, pos} !== {1'b0, BLINK, 4'd0}) begin
            n_bad++;
            $display("FAIL tick_pause_held: en,blank,pos=%b,%b,%0d want 0,%b,0", sh_en, blank, pos, BLINK);
        end
        cyc(1, 1, 1, 0);
        n_cmp++;
        if ({sh_ld, blank} !== 2'b10) begin
            n_bad++;
            $display("FAIL start_pause: ld,blank=%b,%b want 1,0", sh_ld, blank);
        end
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        n_cmp++;
        if ({sh_en, pos} !== {1'b1, 4'd1}) begin
            n_bad++;
            $display("FAIL start_pause_run: en,pos=%b,%0d want 1,1", sh_en, pos);
        end
    endtask

    task automatic test_continuous();
        int n_lap = 0;
        int n_idle = 0;
        dir = 1'b0; mode_once = 1'b0;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 34; i++) begin
            cyc(1, 0, 0, 1);
            n_lap += int'(lap_done);
            n_idle += int'(!busy);
            if (i == 33) begin
                n_cmp++;
                if ({sh_en, pos} !== {1'b0, 4'd0}) begin
                    n_bad++;
                    $display("FAIL cont_hold: en,pos=%b,%0d want 0,0", sh_en, pos);
                end
            end
            cyc(1, 0, 0, 0);
            n_lap += int'(lap_done);
            n_idle += int'(!busy);
        end
        n_cmp++;
        if (n_lap != 2 || n_idle != 0) begin
            n_bad++;
            $display("FAIL cont_laps: laps=%0d idle_cycles=%0d want 2,0", n_lap, n_idle);
        end
        cyc(1, 0, 0, 1);
        n_cmp++;
        if ({sh_en, pos} !== {1'b1, 4'd1}) begin
            n_bad++;
            $display("FAIL cont_loop: en,pos=%b,%0d want 1,1", sh_en, pos);
        end
    endtask

    task automatic test_random();
        logic [9:0] got;
        logic [9:0] want;
        bit r, s, p, t;
        cyc(0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 15) == 0) mode_once = ~mode_once;
            r = ($urandom_range(0, 399) != 0);
            s = ($urandom_range(0, 119) == 0);
            p = ($urandom_range(0, 29) == 0);
            t = ($urandom_range(0, 2) == 0);
            cyc(r, s, p, t);
            got  = {sh_ld, sh_en, lap_done, busy,
                    (m_ph == P_LOAD) ? 1'b0 : sh_dir, blank, pos};
            want = {e_ld, e_en, e_lap, (m_ph != P_IDLE),
                    (m_ph == P_IDLE || m_ph == P_LOAD) ? 1'b0 : m_dir,
                    BLINK && (m_ph == P_PAUSE) && m_blink, 4'(m_pos)};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random[%0d]: ld,en,lap,busy,dir,blank,pos got=%b want=%b", n, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_lap();
        test_right_scroll();
        test_pause();
        test_restart_collision();
        test_continuous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/scroll_ctrl.md
# scroll_ctrl

Sequencing controller for the scrolling ID display. It drives the load, step-enable and direction inputs of the 52-bit nibble shifter, and it tracks the window offset. It supports start/restart, pause/resume, scroll direction, single-lap or continuous mode, and an end-of-lap hold. It sits between the clock-divider step pulse (2 Hz class) and the shifter, replacing the direct divider-to-shifter wiring.

## Interface
Parameters:
- DIGITS, 13: nibbles in the message; one lap is DIGITS steps.
- POS_BITS, 4: width of `pos`; must satisfy 2^POS_BITS ≥ DIGITS.
- HOLD_TICKS, 4: ticks held after each completed lap.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle step pulse from the divider.
- start  in  1  one-cycle pulse: (re)load the message and begin scrolling.
- pause  in  1  one-cycle pulse: toggles pause.
- dir  in  1  0 = left (pos increments), 1 = right (pos decrements); sampled in LOAD.
- mode_once  in  1  1 = stop after one lap plus hold; 0 = loop forever; sampled in LOAD.
- sh_ld  out  1  shifter parallel load.
- sh_en  out  1  shifter step enable.
- sh_dir  out  1  shifter direction.
- pos  out  POS_BITS  current window offset, 0..DIGITS-1.
- busy  out  1  high in every state except IDLE.
- lap_done  out  1  one-cycle pulse when a lap completes.
- blank  out  1  display blanking request.

## Operation
- States: IDLE, LOAD, RUN, HOLD, PAUSE.
- IDLE:
  - All outputs are 0.
  - `start` → LOAD.
- LOAD:
  - Lasts exactly one cycle with sh_ld=1 and pos=0.
  - Latches `dir` into sh_dir and latches `mode_once`.
  - → RUN.
- RUN: on each `tick`, sh_en=1 for one cycle and pos steps.
  - dir=0: pos+1, wrapping DIGITS-1→0.
  - dir=1: pos-1, wrapping 0→DIGITS-1.
  - When a step lands on pos=0, the lap is complete: lap_done=1 in the same cycle as that sh_en, then → HOLD.
- HOLD:
  - Counts HOLD_TICKS ticks; no sh_en.
  - After the last hold tick: → IDLE if mode_once is latched, otherwise → RUN.
- PAUSE:
  - Entered by `pause` from RUN or HOLD; the origin state and the hold count are preserved.
  - Ticks are ignored; pos is frozen.
  - `pause` → return to the origin state.
  - `pause` in IDLE or LOAD is ignored.
- Priority when several events fall in one cycle: reset > start > pause > tick.
  - `start` in any state, including PAUSE, → LOAD (restart from pos 0).
  - `tick` together with `pause` in the same cycle: the pause toggle is taken and the tick is dropped.
- Reset mid-operation: → IDLE, pos=0, hold count cleared, all outputs 0 at the next edge.
- Every output resets to 0.

## Timing
- All outputs are registered.
- sh_ld is high in the cycle after `start` is sampled.
- sh_en and the new pos appear in the cycle after `tick` is sampled; latency is 1 cycle.
- lap_done coincides with the sh_en of the wrapping step.
- busy rises with sh_ld and falls in the cycle after the final hold tick.
- The 13th tick after start completes the lap (DIGITS=13).

## Configuration
- Macro: SCROLL_CTRL_BLINK_EN.
- With the macro defined: in PAUSE, `blank` toggles on each `tick`. It starts at 1 on the first tick after entry and is forced to 0 on leaving PAUSE.
- Without the macro: `blank` is tied to 0. The port is kept so the interface does not change.

## Structure
- Shared package scroll_pkg:
  - state encoding constants (3-bit: IDLE=0, LOAD=1, RUN=2, HOLD=3, PAUSE=4);
  - defaults DIGITS_DEF=13 and HOLD_TICKS_DEF=4.
- One natural sub-module, wrap_counter: an up/down modulo-DIGITS position counter with a wrap flag.
- The FSM and hold counter stay in scroll_ctrl.

## Test plan
- Reset: hold reset=0 for 2 cycles mid-RUN → next edge all outputs 0, pos=0, busy=0.
- Single lap: dir=0, mode_once=1, start, then 17 ticks → 1 sh_ld pulse, 13 sh_en pulses with pos 1..12 then 0, lap_done on the 13th, busy=0 after the 17th tick.
- Right scroll: dir=1, start, 1 tick → pos=12, sh_dir=1; 12 more ticks → pos=0 with lap_done.
- Pause: after 3 ticks, pulse pause, 5 ticks, pulse pause, 1 tick → no sh_en during the pause, pos held at 3, then pos=4. With BLINK_EN, blank toggles 1,0,1,0,1 during the pause, then 0.
- Restart and collision:
  - start at pos=7 → sh_ld the next cycle, pos=0.
  - tick+pause in the same cycle → no sh_en, state PAUSE.
  - start+pause in the same cycle → LOAD.
- Continuous: mode_once=0, 34 ticks → two lap_done pulses, busy stays 1, pos=0 in HOLD.
